anim_frame_sequencer: RTL and testbench
=======================================

ANIM_FRAME_SEQUENCER -- requirements
Module: anim_frame_sequencer

Interface
REQ-001 SHALL have parameter NUM_FRAMES, default 8, meaning animation frames per sequence (2..16).
REQ-002 SHALL have parameter DELAY_DONE, default 20'hFFFFF, meaning the frame-delay count value that marks the end of a delay.
REQ-003 SHALL have port clock  in  1  sole clock, all logic on rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have port start  in  1  one-cycle request to begin a sequence.
REQ-006 SHALL have port stop  in  1  request to end a looping sequence (used only with ANIM_LOOP_EN).
REQ-007 SHALL have port frame_delay_count  in  20  current value of the external frame-delay counter.
REQ-008 SHALL have port frame_delay_en  out  1  count enable to the frame-delay counter.
REQ-009 SHALL have port frame_delay_clr  out  1  clear to the frame-delay counter, active-high.
REQ-010 SHALL have port draw_req  out  1  request to the drawer to render frame_idx.
REQ-011 SHALL have port draw_ack  in  1  drawer completion, one-cycle pulse.
REQ-012 SHALL have port frame_idx  out  4  index of the frame being drawn.
REQ-013 SHALL have port busy  out  1  high in every state except IDLE.
REQ-014 SHALL have port done  out  1  one-cycle pulse at sequence end.

Function
REQ-015 SHALL implement states IDLE, CLEAR, WAIT_DELAY, DRAW, ADVANCE, FINISH.
REQ-016 IDLE: start=1 -> CLEAR next cycle with frame_idx=0; otherwise remain.
REQ-017 CLEAR: frame_delay_clr=1 for exactly one cycle, frame_delay_en=0; -> WAIT_DELAY unconditionally.
REQ-018 WAIT_DELAY: frame_delay_en=1; frame_delay_count==DELAY_DONE (full 20-bit compare) -> DRAW, with frame_delay_en=0 from the cycle DRAW is entered.
REQ-019 DRAW: draw_req=1, held until the cycle draw_ack=1 is sampled; then -> FINISH if frame_idx==NUM_FRAMES-1, else -> ADVANCE.
REQ-020 ADVANCE: frame_idx increments by 1 for one cycle; -> CLEAR.
REQ-021 FINISH: done=1 for one cycle; -> IDLE; frame_idx retains final value.
REQ-022 start outside IDLE SHALL be ignored; start and done in the same cycle SHALL NOT restart the sequence.
REQ-023 draw_ack outside DRAW SHALL be ignored, including one arriving in the same cycle DRAW is entered from WAIT_DELAY.
REQ-024 A count already equal to DELAY_DONE upon entering WAIT_DELAY is impossible after CLEAR; if present, it SHALL be honored (transition next cycle).
REQ-025 frame_delay_clr and frame_delay_en SHALL never be high in the same cycle.
REQ-026 All outputs SHALL be registered; outputs are functions of the current state only.

Reset
REQ-027 reset=1 SHALL force IDLE, frame_idx=0, and frame_delay_en, frame_delay_clr, draw_req, busy, done all 0 on the next edge.
REQ-028 reset mid-sequence SHALL abandon the sequence with no done pulse; reset overrides start.

Configuration
REQ-029 Macro ANIM_LOOP_EN defined: at frame_idx==NUM_FRAMES-1 with draw_ack, the FSM SHALL go to ADVANCE and wrap frame_idx to 0, continuing indefinitely; stop=1 sampled in any non-IDLE state SHALL be latched and take effect at the next draw_ack, which then goes to FINISH.
REQ-030 Macro ANIM_LOOP_EN undefined: stop SHALL be ignored and the sequence SHALL end after one pass (REQ-019).

Structure
REQ-031 State encoding typedef and the default DELAY_DONE constant SHALL be placed in the shared package anim_pkg.
REQ-032 Single module; no sub-module. The frame-delay counter stays an external block driven by frame_delay_en/frame_delay_clr.

Verification
REQ-033 NUM_FRAMES=3, DELAY_DONE=20'd15, counter model attached, start pulse, draw_ack 2 cycles after each draw_req -> 3 draw_req with frame_idx 0,1,2, each preceded by 1 clr cycle and 16 en cycles, then one done pulse, busy low after.
REQ-034 start pulsed repeatedly during WAIT_DELAY -> no restart; frame_idx sequence unchanged.
REQ-035 reset asserted in DRAW with frame_idx=1 -> next cycle IDLE, frame_idx=0, draw_req=0, no done pulse.
REQ-036 draw_ack pulsed during WAIT_DELAY and in the cycle DRAW is entered -> ignored; draw_req stays high until a later draw_ack.
REQ-037 ANIM_LOOP_EN, NUM_FRAMES=2, stop pulsed during second pass at frame_idx=0 -> frame_idx 0,1,0,1 observed, done after the draw_ack of frame 1 in the second pass.
REQ-038 Assertion across all tests: frame_delay_clr&frame_delay_en never 1; done only ever one cycle wide.

Source files
------------

// File: rtl/anim_pkg.sv
// Shared types and constants for the animation frame sequencer.
package anim_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_WAIT,
        S_DRAW,
        S_ADVANCE,
        S_FINISH
    } anim_state_t;

    localparam logic [19:0] DELAY_DONE_DEF = 20'hFFFFF;

endpackage

// File: rtl/anim_frame_sequencer.sv
// Steps through animation frames: clear delay, wait, request draw, advance.
// Define ANIM_LOOP_EN to loop passes until stop is requested.
module anim_frame_sequencer
    import anim_pkg::*;
#(
    parameter int          NUM_FRAMES = 8,
    parameter logic [19:0] DELAY_DONE = DELAY_DONE_DEF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        stop,
    input  logic [19:0] frame_delay_count,
    output logic        frame_delay_en,
    output logic        frame_delay_clr,
    output logic        draw_req,
    input  logic        draw_ack,
    output logic [3:0]  frame_idx,
    output logic        busy,
    output logic        done
);

    localparam logic [3:0] LAST_IDX = 4'(NUM_FRAMES - 1);

    anim_state_t state;
    anim_state_t next_state;
    logic        last;
    logic        stop_pend;

    assign last = (frame_idx == LAST_IDX);

`ifdef ANIM_LOOP_EN
    logic stop_q;

    // A stop request ends the sequence at the next end-of-pass ack.
    always_ff @(posedge clock) begin
        if (reset || state == S_IDLE) begin
            stop_q <= 1'b0;
        end else if (stop) begin
            stop_q <= 1'b1;
        end
    end

    assign stop_pend = stop_q | (stop && state != S_IDLE);
`else
    logic unused_stop;

    assign unused_stop = stop;
    assign stop_pend   = 1'b1;
`endif

    always_comb begin
        next_state = state;
        unique case (state)
            S_IDLE:    if (start) next_state = S_CLEAR;
            S_CLEAR:   next_state = S_WAIT;
            S_WAIT: begin
                if (frame_delay_count == DELAY_DONE) begin
                    next_state = S_DRAW;
                end
            end
            S_DRAW: begin
                if (draw_ack) begin
                    next_state = (last && stop_pend) ? S_FINISH
                                                     : S_ADVANCE;
                end
            end
            S_ADVANCE: next_state = S_CLEAR;
            S_FINISH:  next_state = S_IDLE;
            default:   next_state = S_IDLE;
        endcase
    end

    // Outputs are registered from next_state so they track state exactly.
    always_ff @(posedge clock) begin
        if (reset) begin
            state           <= S_IDLE;
            frame_idx       <= 4'd0;
            frame_delay_en  <= 1'b0;
            frame_delay_clr <= 1'b0;
            draw_req        <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
        end else begin
            state           <= next_state;
            frame_delay_clr <= (next_state == S_CLEAR);
            frame_delay_en  <= (next_state == S_WAIT);
            draw_req        <= (next_state == S_DRAW);
            busy            <= (next_state != S_IDLE);
            done            <= (next_state == S_FINISH);
            if (state == S_IDLE && next_state == S_CLEAR) begin
                frame_idx <= 4'd0;
            end else if (next_state == S_ADVANCE) begin
                frame_idx <= last ? 4'd0 : 4'(frame_idx + 4'd1);
            end
        end
    end

endmodule

// File: tb/tb_anim_frame_sequencer.sv
// Directed scoreboard bench for anim_frame_sequencer with counter model.
module tb_anim_frame_sequencer;

`ifdef ANIM_LOOP_EN
    localparam int NF = 2;
`else
    localparam int NF = 3;
`endif
    localparam logic [19:0] DD = 20'd15;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        draw_ack = 1'b0;
    logic [19:0] frame_delay_count = '0;
    logic        frame_delay_en;
    logic        frame_delay_clr;
    logic        draw_req;
    logic        busy;
    logic        done;
    logic [3:0]  frame_idx;

    int   n_cmp = 0;
    int   n_err = 0;
    int   exp_q[$];
    int   clr_n = 0;
    int   en_n = 0;
    int   done_cnt = 0;
    int   draw_cnt = 0;
    int   age = 0;
    int   d0;
    logic prev_req = 1'b0;
    logic prev_done = 1'b0;
    logic auto_ack = 1'b0;
    logic found;

    anim_frame_sequencer #(
        .NUM_FRAMES(NF),
        .DELAY_DONE(DD)
    ) dut (
        .clock(clock),
        .reset(reset),
        .start(start),
        .stop(stop),
        .frame_delay_count(frame_delay_count),
        .frame_delay_en(frame_delay_en),
        .frame_delay_clr(frame_delay_clr),
        .draw_req(draw_req),
        .draw_ack(draw_ack),
        .frame_idx(frame_idx),
        .busy(busy),
        .done(done)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (frame_delay_clr) begin
            frame_delay_count <= '0;
        end else if (frame_delay_en) begin
            frame_delay_count <= frame_delay_count + 20'd1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "bench timed out");
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic monitor();
        if (reset) begin
            clr_n     = 0;
            en_n      = 0;
            prev_req  = 1'b0;
            prev_done = 1'b0;
            return;
        end
        check("clr_en_exclusive", 32'(frame_delay_clr & frame_delay_en), 0);
        if (done) begin
            check("done_width", 32'(prev_done), 0);
            done_cnt++;
        end
        if (draw_req && !prev_req) begin
            draw_cnt++;
            check("draw_expected", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                check("draw_frame_idx", 32'(frame_idx), exp_q.pop_front());
            end
            check("clr_cycles", clr_n, 1);
            check("en_cycles", en_n, 32'(DD) + 1);
            clr_n = 0;
            en_n  = 0;
        end
        clr_n     += int'(frame_delay_clr);
        en_n      += int'(frame_delay_en);
        prev_req  = draw_req;
        prev_done = done;
    endtask

    task automatic drawer();
        if (!auto_ack) return;
        draw_ack = 1'b0;
        if (draw_req && !reset) begin
            age++;
            if (age == 2) begin
                draw_ack = 1'b1;
                age      = 0;
            end
        end else begin
            age = 0;
        end
    endtask

    task automatic cycle();
        @(negedge clock);
        monitor();
        drawer();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cycle();
        start = 1'b0;
    endtask

    task automatic run_until_done(input int budget);
        int base;
        base = done_cnt;
        for (int i = 0; i < budget; i++) begin
            cycle();
            if (done_cnt != base) break;
        end
        check("done_in_budget", 32'(done_cnt != base), 1);
    endtask

    task automatic wait_count(input logic [19:0] c, input int budget);
        found = 1'b0;
        for (int i = 0; i < budget; i++) begin
            cycle();
            if (frame_delay_en && frame_delay_count == c) begin
                found = 1'b1;
                break;
            end
        end
        check("count_reached", 32'(found), 1);
    endtask

    initial begin
        repeat (3) cycle();
        reset = 1'b0;
        cycle();
        check("rst_busy", 32'(busy), 0);
        check("rst_draw_req", 32'(draw_req), 0);
        check("rst_done", 32'(done), 0);
        check("rst_en", 32'(frame_delay_en), 0);
        check("rst_clr", 32'(frame_delay_clr), 0);
        check("rst_frame_idx", 32'(frame_idx), 0);

`ifdef ANIM_LOOP_EN
        exp_q    = '{0, 1, 0, 1};
        auto_ack = 1'b1;
        d0       = draw_cnt;
        pulse_start();
        found = 1'b0;
        for (int i = 0; i < 300; i++) begin
            cycle();
            if (draw_cnt - d0 == 3) begin
                found = 1'b1;
                break;
            end
        end
        check("loop_third_draw", 32'(found), 1);
        check("loop_pass2_idx", 32'(frame_idx), 0);
        stop = 1'b1;
        cycle();
        stop = 1'b0;
        run_until_done(300);
        check("loop_draws", draw_cnt - d0, 4);
        check("loop_queue_empty", exp_q.size(), 0);
        cycle();
        check("loop_busy_after", 32'(busy), 0);
        check("loop_done_total", done_cnt, 1);
`else
        // Full pass with automatic drawer; stop must be ignored.
        exp_q    = '{0, 1, 2};
        auto_ack = 1'b1;
        pulse_start();
        check("t1_clr_first", 32'(frame_delay_clr), 1);
        check("t1_busy", 32'(busy), 1);
        check("t1_idx0", 32'(frame_idx), 0);
        stop = 1'b1;
        cycle();
        stop = 1'b0;
        run_until_done(300);
        check("t1_final_idx", 32'(frame_idx), 2);
        cycle();
        check("t1_busy_after", 32'(busy), 0);
        check("t1_done_after", 32'(done), 0);
        check("t1_idx_kept", 32'(frame_idx), 2);
        check("t1_queue_empty", exp_q.size(), 0);
        check("t1_done_total", done_cnt, 1);

        // start spam during delay and start coincident with done.
        exp_q = '{0, 1, 2};
        d0    = done_cnt;
        pulse_start();
        for (int i = 0; i < 300; i++) begin
            cycle();
            if (done_cnt != d0) break;
            start = frame_delay_en && !start;
        end
        check("t2_done_seen", done_cnt - d0, 1);
        start = 1'b1;
        cycle();
        start = 1'b0;
        repeat (3) cycle();
        check("t2_no_restart", 32'(busy), 0);
        check("t2_queue_empty", exp_q.size(), 0);
        check("t2_done_total", done_cnt - d0, 1);

        // Reset while drawing frame 1.
        exp_q = '{0, 1};
        d0    = done_cnt;
        pulse_start();
        found = 1'b0;
        for (int i = 0; i < 300; i++) begin
            cycle();
            if (draw_req && frame_idx == 4'd1) begin
                found = 1'b1;
                break;
            end
        end
        check("t3_draw1_reached", 32'(found), 1);
        reset = 1'b1;
        cycle();
        check("t3_busy", 32'(busy), 0);
        check("t3_draw_req", 32'(draw_req), 0);
        check("t3_idx", 32'(frame_idx), 0);
        start = 1'b1;
        cycle();
        check("t3_reset_over_start", 32'(busy), 0);
        reset = 1'b0;
        start = 1'b0;
        repeat (4) cycle();
        check("t3_idle", 32'(busy), 0);
        check("t3_no_done", done_cnt - d0, 0);
        check("t3_queue_empty", exp_q.size(), 0);

        // draw_ack outside DRAW must be ignored.
        auto_ack = 1'b0;
        exp_q    = '{0, 1, 2};
        d0       = done_cnt;
        pulse_start();
        wait_count(20'd5, 50);
        draw_ack = 1'b1;
        cycle();
        draw_ack = 1'b0;
        check("t4_still_wait", 32'(frame_delay_en), 1);
        check("t4_no_req_early", 32'(draw_req), 0);
        wait_count(DD, 50);
        draw_ack = 1'b1;
        cycle();
        draw_ack = 1'b0;
        check("t4_req_entered", 32'(draw_req), 1);
        repeat (3) cycle();
        check("t4_req_held", 32'(draw_req), 1);
        draw_ack = 1'b1;
        cycle();
        draw_ack = 1'b0;
        check("t4_req_released", 32'(draw_req), 0);
        auto_ack = 1'b1;
        run_until_done(300);
        check("t4_queue_empty", exp_q.size(), 0);
        check("t4_done_total", done_cnt - d0, 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
